config_bus_arbiter: RTL

- Master for the IO multiplexer configuration bus (config_we / config_oe / config_address / config_data).
- Shares that bus between two requesters: the management-core Wishbone slave port, and a logic-analyzer debug port driven from la_data_in.
- Serialises accesses through a fixed-length access FSM with round-robin arbitration.
- Returns read data and a single-cycle acknowledge to whichever requester was granted.

---
 rtl/config_bus_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/config_bus_arbiter.sv
// config_bus_arbiter
//
// Master for the IO multiplexer configuration bus. Two requesters share the
// bus: the management-core Wishbone slave port and a logic-analyzer debug
// port. One access runs at a time through IDLE -> ACCESS -> DONE. In ACCESS,
// config_we or config_oe is held high for ACCESS_CYCLES cycles. In DONE, the
// granted requester receives a single-cycle acknowledge. When both requesters
// are pending in IDLE, the one that was not granted last wins.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   wbs_*               Wishbone slave port (only in-window cycles are served)
//   la_req/we/addr/wdata debug request, level-held until la_ack
//   la_ack, la_rdata    debug acknowledge and last captured read data
//   config_we/oe        write / read strobes, high only during ACCESS
//   config_sel/address/wdata  latched access attributes, held while idle
//   config_rdata        read data returned by the mux
//   busy                high whenever an access is in progress (not IDLE)
module config_bus_arbiter #(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK     = 32'hFFF0_0000,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        la_req,
  input  logic        la_we,
  input  logic [31:0] la_addr,
  input  logic [31:0] la_wdata,
  output logic        la_ack,
  output logic [31:0] la_rdata,
  output logic        config_we,
  output logic        config_oe,
  output logic [3:0]  config_sel,
  output logic [31:0] config_address,
  output logic [31:0] config_wdata,
  input  logic [31:0] config_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] COUNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] count;
  logic       gnt_la;        // current grant belongs to the LA port
  logic       last_la;       // round-robin pointer: last completed grant was LA
  logic       lat_we;
  logic       wb_req;
  logic       grant;
  logic       grant_la_next;
  logic       access_last;

  assign wb_req = wbs_cyc_i & wbs_stb_i &
                  ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);

  assign access_last = (state == ACCESS) && (count == '0);
  assign busy        = (state != IDLE);

  always_comb begin
    state_next    = state;
    grant         = 1'b0;
    grant_la_next = 1'b0;
    config_we     = 1'b0;
    config_oe     = 1'b0;
    case (state)
      IDLE: begin
        if (wb_req || la_req) begin
          grant = 1'b1;
          // On a tie, pick the requester that was not granted last;
          // otherwise pick whichever one is asking.
          grant_la_next = (wb_req && la_req) ? ~last_la : la_req;
          state_next    = ACCESS;
        end
      end
      ACCESS: begin
        config_we = lat_we;
        config_oe = ~lat_we;
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= '0;
      gnt_la         <= 1'b0;
      last_la        <= 1'b1;
      lat_we         <= 1'b0;
      config_sel     <= '0;
      config_address <= '0;
      config_wdata   <= '0;
      wbs_dat_o      <= '0;
      la_rdata       <= '0;
      wbs_ack_o      <= 1'b0;
      la_ack         <= 1'b0;
    end else begin
      state     <= state_next;
      wbs_ack_o <= 1'b0;
      la_ack    <= 1'b0;

      if (grant) begin
        gnt_la <= grant_la_next;
        count  <= COUNT_LOAD;
        if (grant_la_next) begin
          lat_we         <= la_we;
          config_sel     <= '1;
          config_address <= la_addr;
          config_wdata   <= la_wdata;
        end else begin
          lat_we         <= wbs_we_i;
          config_sel     <= wbs_sel_i;
          config_address <= wbs_adr_i & ~ADDR_MASK;
          config_wdata   <= wbs_dat_i;
        end
      end

      if (state == ACCESS && count != '0) begin
        count <= count - 4'd1;
      end

      // The ack is registered on the ACCESS->DONE edge, so it is high for
      // exactly the DONE cycle.
      if (access_last) begin
        if (!lat_we) begin
          if (gnt_la) begin
            la_rdata <= config_rdata;
          end else begin
            wbs_dat_o <= config_rdata;
          end
        end
        wbs_ack_o <= ~gnt_la;
        la_ack    <= gnt_la;
      end

      if (state == DONE) begin
        last_la <= gnt_la;
      end
    end
  end

endmodule
